// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the N-bank sequencer controller.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_ISSUE = 3'd1,
    LD_G0    = 3'd2,
    LD_WAIT  = 3'd3,
    EXE      = 3'd4,
    FIN      = 3'd5,
    ERR_S    = 3'd6
  } state_e;

  localparam int unsigned DEF_PRELOAD = 1;
  localparam int unsigned DEF_TMO     = 1024;

  function automatic int unsigned calc_bw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_ctrl_wdog.sv
// Memory-busy watchdog: counts enabled cycles and flags the TMO-th one.
// A TMO of zero disables the flag entirely.
module seq_ctrl_wdog
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned TMO = DEF_TMO
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tmo_o
);

  localparam int unsigned CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + CW'(1);
  end

  // Flag fires combinationally on the cycle that would be the TMO-th busy cycle.
  assign tmo_o = (TMO != 0) && en_i && !clr_i && (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_ctrl_nbank.sv
// N-bank instruction loader / sequencer controller with preload depth,
// abort, restart, memory-busy watchdog and load counter.
module seq_ctrl_nbank
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned NBANK   = 2,
  parameter int unsigned PRELOAD = DEF_PRELOAD,
  parameter int unsigned TMO     = DEF_TMO,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned BW     = calc_bw(NBANK)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             restart_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             seq_purge_o,
  input  logic             seq_load_i,
  input  logic             seq_fin_i,
  output logic             mstart_o,
  input  logic             mbusy_i,
  output logic [BW-1:0]    banki_o,
  output logic [BW-1:0]    bankx_o,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic             err_o
);

  localparam int unsigned FW = calc_bw(PRELOAD + 1);

  state_e           state_q, state_d;
  logic             start_pend_q, start_pend_d;
  logic             load_req_q, load_req_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [BW-1:0]    banki_q, banki_d, bankx_q, bankx_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d, purge_q, purge_d, mstart_q, mstart_d;
  logic             wd_clr, wd_en, wd_tmo;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == BW'(NBANK - 1)) ? '0 : b + BW'(1);
  endfunction

  assign wd_clr = (state_q != LD_WAIT) || abort_i || restart_i;
  assign wd_en  = (state_q == LD_WAIT) && mbusy_i;

  seq_ctrl_wdog #(.TMO(TMO)) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tmo_o (wd_tmo)
  );

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    load_req_d   = load_req_q;
    fill_d       = fill_q;
    banki_d      = banki_q;
    bankx_d      = bankx_q;
    load_cnt_d   = load_cnt_q;
    err_d        = err_q;

    if (abort_i) begin
      start_pend_d = 1'b0;
      load_req_d   = 1'b0;
      if (state_q != IDLE) state_d = FIN;
    end else if (restart_i) begin
      start_pend_d = 1'b0;
      load_req_d   = 1'b0;
      state_d      = EXE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) start_pend_d = 1'b1;
          if (start_pend_q && !mbusy_i) begin
            state_d      = LD_ISSUE;
            start_pend_d = 1'b0;
            err_d        = 1'b0;
            load_cnt_d   = '0;
            fill_d       = '0;
            banki_d      = '0;
            bankx_d      = '0;
          end
        end
        LD_ISSUE: state_d = LD_G0;
        LD_G0:    state_d = LD_WAIT;
        LD_WAIT: begin
          if (!mbusy_i) begin
            banki_d    = bank_inc(banki_q);
            load_cnt_d = load_cnt_q + CNT_W'(1);
            // fill saturates so steady-state reloads never wrap back into preload
            if (int'(fill_q) < int'(PRELOAD)) fill_d = fill_q + FW'(1);
            state_d = (int'(fill_q) + 1 < int'(PRELOAD)) ? LD_ISSUE : EXE;
          end else if (wd_tmo) begin
            state_d = ERR_S;
          end
        end
        EXE: begin
          if (seq_fin_i) begin
            state_d    = FIN;
            load_req_d = 1'b0;
          end else if (load_req_q && !mbusy_i) begin
            bankx_d    = bank_inc(bankx_q);
            load_req_d = 1'b0;
            state_d    = LD_ISSUE;
          end else if (seq_load_i) begin
            load_req_d = 1'b1;
          end
        end
        FIN: state_d = IDLE;
        ERR_S: begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the present state and registered.
  always_comb begin
    busy_d   = (state_q != IDLE);
    purge_d  = (state_q != EXE) || restart_i;
    mstart_d = (state_q == LD_ISSUE) && !abort_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      start_pend_q <= 1'b0;
      load_req_q   <= 1'b0;
      fill_q       <= '0;
      banki_q      <= '0;
      bankx_q      <= '0;
      load_cnt_q   <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      purge_q      <= 1'b1;
      mstart_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      load_req_q   <= load_req_d;
      fill_q       <= fill_d;
      banki_q      <= banki_d;
      bankx_q      <= bankx_d;
      load_cnt_q   <= load_cnt_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      purge_q      <= purge_d;
      mstart_q     <= mstart_d;
    end
  end

  assign busy_o      = busy_q;
  assign seq_purge_o = purge_q;
  assign mstart_o    = mstart_q;
  assign banki_o     = banki_q;
  assign bankx_o     = bankx_q;
  assign load_cnt_o  = load_cnt_q;
  assign err_o       = err_q;

endmodule
